// File: rtl/tx_frame_scheduler.sv
// Round-robin frame scheduler feeding the Ethernet TX wrapper: streams the granted
// requester's words, pads short frames, truncates long ones and paces frames with a gap.
module tx_frame_scheduler #(
  parameter int N_REQ      = 2,
  parameter int MIN_WORDS  = 15,
  parameter int MAX_WORDS  = 379,
  parameter int IFG_CYCLES = 16
) (
  input  logic                 clk_100_mhz,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 ready_to_write,
  input  logic                 ready_to_send,
  output logic [31:0]          data_out,
  output logic                 valid_out,
  output logic                 last_out,
  output logic                 send,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic                 trunc_pulse,
  output logic [15:0]          frame_cnt
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  localparam logic [8:0]       MIN_CNT  = 9'(MIN_WORDS);
  localparam logic [8:0]       MAX_CNT  = 9'(MAX_WORDS);
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES);
  localparam logic [1:0]       GRANT_RESET = 2'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DROP,
    S_PAD,
    S_LAST,
    S_WAIT_RTS,
    S_WAIT_DONE,
    S_IFG
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [8:0]        r_wordCnt;
  logic [8:0]        w_wordCntNext;
  logic [8:0]        w_cntInc;
  logic [IFG_W-1:0]  r_ifgCnt;
  logic [IFG_W-1:0]  w_ifgCntNext;
  logic [1:0]        r_grant;
  logic [1:0]        w_grantNext;
  logic [15:0]       r_frameCnt;
  logic [15:0]       w_frameCntNext;

  logic [31:0]       r_dataOut;
  logic              r_validOut;
  logic              r_lastOut;
  logic              r_send;
  logic              r_busy;
  logic              r_trunc;

  logic [31:0]       w_dataNext;
  logic              w_validNext;
  logic              w_lastNext;
  logic              w_sendNext;
  logic              w_truncNext;

  logic              w_readyState;
  logic              w_grantValid;
  logic              w_grantLast;
  logic [31:0]       w_grantData;
  logic              w_accept;
  logic [3:0]        w_validPad;
  logic [2:0]        w_idx;
  logic              w_found;
  logic [1:0]        w_rrPick;

  assign w_readyState = (r_state == S_STREAM) || (r_state == S_DROP);
  assign w_cntInc     = r_wordCnt + 9'd1;
  assign w_validPad   = 4'(req_valid);

  always_comb begin
    req_ready    = '0;
    w_grantValid = 1'b0;
    w_grantLast  = 1'b0;
    w_grantData  = 32'h0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == 2'(i)) begin
        req_ready[i] = w_readyState;
        w_grantValid = req_valid[i];
        w_grantLast  = req_last[i];
        w_grantData  = req_data[32*i +: 32];
      end
    end
  end

  assign w_accept = w_grantValid && w_readyState;

  // Search starts one past the last grant so a waiting requester always goes next.
  always_comb begin
    w_found  = 1'b0;
    w_rrPick = r_grant;
    w_idx    = 3'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = 3'(r_grant) + 3'(k);
      if (w_idx >= 3'(N_REQ)) begin
        w_idx = w_idx - 3'(N_REQ);
      end
      if (!w_found && w_validPad[w_idx[1:0]]) begin
        w_found  = 1'b1;
        w_rrPick = w_idx[1:0];
      end
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_wordCntNext  = r_wordCnt;
    w_ifgCntNext   = r_ifgCnt;
    w_grantNext    = r_grant;
    w_frameCntNext = r_frameCnt;
    w_dataNext     = 32'h0;
    w_validNext    = 1'b0;
    w_lastNext     = 1'b0;
    w_sendNext     = 1'b0;
    w_truncNext    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grantNext   = w_rrPick;
          w_wordCntNext = 9'd0;
          w_stateNext   = S_STREAM;
        end
      end

      // The length cap is tested before the pad decision, so a frame ending exactly at MAX is kept.
      S_STREAM: begin
        if (w_accept) begin
          w_validNext   = 1'b1;
          w_dataNext    = w_grantData;
          w_wordCntNext = w_cntInc;
          if (!w_grantLast && (w_cntInc == MAX_CNT)) begin
            w_stateNext = S_DROP;
            w_truncNext = 1'b1;
          end else if (w_grantLast) begin
            w_stateNext = (w_cntInc < MIN_CNT) ? S_PAD : S_LAST;
          end
        end
      end

      S_DROP: begin
        if (w_accept && w_grantLast) begin
          w_stateNext = S_LAST;
        end
      end

      S_PAD: begin
        w_validNext   = 1'b1;
        w_wordCntNext = w_cntInc;
        if (w_cntInc >= MIN_CNT) begin
          w_stateNext = S_LAST;
        end
      end

      S_LAST: begin
        w_lastNext  = 1'b1;
        w_stateNext = S_WAIT_RTS;
      end

      S_WAIT_RTS: begin
        if (ready_to_send) begin
          w_sendNext     = 1'b1;
          w_frameCntNext = r_frameCnt + 16'd1;
          w_stateNext    = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (ready_to_write) begin
          w_ifgCntNext = IFG_LOAD;
          w_stateNext  = S_IFG;
        end
      end

      S_IFG: begin
        if (r_ifgCnt == '0) begin
          w_stateNext = S_IDLE;
        end else begin
          w_ifgCntNext = r_ifgCnt - 1'b1;
        end
      end

      default: begin
        w_stateNext = S_IFG;
      end
    endcase
  end

  always_ff @(posedge clk_100_mhz) begin
    if (!rst_n) begin
      r_state    <= S_IFG;
      r_ifgCnt   <= IFG_LOAD;
      r_wordCnt  <= 9'd0;
      r_grant    <= GRANT_RESET;
      r_frameCnt <= 16'd0;
      r_dataOut  <= 32'h0;
      r_validOut <= 1'b0;
      r_lastOut  <= 1'b0;
      r_send     <= 1'b0;
      r_busy     <= 1'b0;
      r_trunc    <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_ifgCnt   <= w_ifgCntNext;
      r_wordCnt  <= w_wordCntNext;
      r_grant    <= w_grantNext;
      r_frameCnt <= w_frameCntNext;
      r_dataOut  <= w_dataNext;
      r_validOut <= w_validNext;
      r_lastOut  <= w_lastNext;
      r_send     <= w_sendNext;
      r_busy     <= (w_stateNext != S_IDLE);
      r_trunc    <= w_truncNext;
    end
  end

  assign data_out    = r_dataOut;
  assign valid_out   = r_validOut;
  assign last_out    = r_lastOut;
  assign send        = r_send;
  assign busy        = r_busy;
  assign grant_id    = r_grant;
  assign trunc_pulse = r_trunc;
  assign frame_cnt   = r_frameCnt;

endmodule
